// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic CS_ACTIVE       = 1'b0;  // chip select is active-low
    localparam logic WR_LOAD         = 1'b1;  // wr = 1 means load
    localparam int   DEPTH_WORDS_DEF = 1024;

endpackage

// File: rtl/dmem_sram_array.sv
// Synchronous single-port word array with per-byte write enables.
// The read port is registered. It only updates on an enabled access with no
// write lanes set, so the last load result is held across stores and idle cycles.
module dmem_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Byte-masked write or registered word read on an enabled access.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we == 4'b0000) begin
                o_rdata <= r_mem[i_idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: captures one load/store request, waits LATENCY
// cycles with the pipeline stalled, then performs the array access on the
// edge entering RESP.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_wr,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_wr,
    output logic [31:0] o_data_rd,
    output logic        o_stall,
    output logic        o_addr_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int AW = IW + 2;  // first byte-address bit that is out of range

    dmem_state_e r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic        r_rd_sel;    // 0 forces data_rd to zero (after reset or bad load)
    logic        r_addr_err;

    logic        w_accept;
    logic        w_go_resp;
    logic        w_req_wr;
    logic [3:0]  w_req_mask;
    logic [31:2] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_oor;
    logic        w_is_load;
    logic        w_sram_en;
    logic [3:0]  w_sram_we;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte offset is the upstream unit's concern; never used here.
    assign w_unused = &{1'b0, i_addr[1:0]};

    assign w_accept = (r_state == IDLE) && (i_cs == CS_ACTIVE);

    // With LATENCY = 1 the access happens on the capture edge, so the live
    // inputs stand in for the request registers while in IDLE.
    assign w_req_wr    = (r_state == IDLE) ? i_wr         : r_wr;
    assign w_req_mask  = (r_state == IDLE) ? i_mask       : r_mask;
    assign w_req_addr  = (r_state == IDLE) ? i_addr[31:2] : r_addr;
    assign w_req_wdata = (r_state == IDLE) ? i_data_wr    : r_wdata;

    assign w_oor     = |w_req_addr[31:AW];
    assign w_is_load = (w_req_wr == WR_LOAD);

    // Reset on the edge that would enter RESP wins: no array access.
    // A zero-mask store never touches the array, keeping the read port stable.
    assign w_sram_en = w_go_resp && !i_rst && !w_oor && (w_is_load || (|w_req_mask));
    assign w_sram_we = w_is_load ? 4'b0000 : w_req_mask;

    dmem_sram_array #(
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_array (
        .i_clk   (i_clk),
        .i_en    (w_sram_en),
        .i_we    (w_sram_we),
        .i_idx   (w_req_addr[AW-1:2]),
        .i_wdata (w_req_wdata),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, stall and the "entering RESP" strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_go_resp   = 1'b0;
        o_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cs == CS_ACTIVE) begin
                    o_stall = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_go_resp   = 1'b1;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                    w_go_resp   = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter and response flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_mask     <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rd_sel   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr    <= i_wr;
                r_mask  <= i_mask;
                r_addr  <= i_addr[31:2];
                r_wdata <= i_data_wr;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_addr_err <= w_go_resp && w_oor;
            if (w_go_resp && w_is_load) r_rd_sel <= !w_oor;
        end
    end

    assign o_data_rd  = r_rd_sel ? w_rdata : 32'd0;
    assign o_addr_err = r_addr_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized and directed checks of dmem_ctrl against a word-array model.
module tb_dmem_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic        wr = 1'b1;
    logic [3:0]  mask = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_wr = 32'd0;
    logic [31:0] data_rd;
    logic        stall;
    logic        addr_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_rd = 32'd0;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_cs      (cs),
        .i_wr      (wr),
        .i_mask    (mask),
        .i_addr    (addr),
        .i_data_wr (data_wr),
        .o_data_rd (data_rd),
        .o_stall   (stall),
        .o_addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h, required %08h", tag, got, want);
    endtask

    // Model of one completed access, from the byte-lane rules.
    task automatic model(input logic w, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, output logic oor);
        int idx;
        oor = (a >> 12) != 0;
        idx = int'(a[11:2]);
        if (w) begin
            exp_rd = oor ? 32'd0 : mem_m[idx];
        end else if (!oor) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // One access; hold keeps cs low and inputs steady throughout.
    task automatic access(input logic w, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        logic oor;
        @(negedge clk);
        cs = 1'b0; wr = w; mask = m; addr = a; data_wr = d;
        #1 chk("stall_req", 32'(stall), 32'd1);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            if (!hold) begin
                // Junk during BUSY must be ignored.
                cs = 1'($urandom); wr = 1'($urandom); mask = 4'($urandom);
                addr = $urandom; data_wr = $urandom;
            end
            #1 chk("stall_busy", 32'(stall), 32'd1);
        end
        @(negedge clk);
        model(w, m, a, d, oor);
        #1;
        chk("stall_resp", 32'(stall), 32'd0);
        chk("addr_err", 32'(addr_err), 32'(oor));
        chk("data_rd", data_rd, exp_rd);
        if (!hold) cs = 1'b1;
    endtask

    // Store aborted by reset in busy cycle k (1..LAT-1).
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int k);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = a; data_wr = d;
        repeat (k) @(negedge clk);
        cs = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 32'd0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_rd", data_rd, 32'd0);
        chk("abort_err", 32'(addr_err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rd", data_rd, 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Give the words used below known contents.
        for (int i = 0; i < 16; i++) access(1'b0, 4'hF, 32'(i * 4), $urandom, 1'b0);

        access(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("full_word", data_rd, 32'hDEADBEEF);
        access(1'b0, 4'b0010, 32'h10, 32'h0000AA00, 1'b0);
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("lane1", data_rd, 32'hDEADAAEF);
        access(1'b0, 4'b0000, 32'h10, 32'h11223344, 1'b0);
        access(1'b1, 4'h0, 32'h13, 32'h0, 1'b0);
        chk("mask0", data_rd, 32'hDEADAAEF);

        // cs held low across two loads: stall 1,1,1,0,1,1,1,0.
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
        access(1'b1, 4'h0, 32'h04, 32'h0, 1'b1);
        @(negedge clk); cs = 1'b1;

        // Out of range.
        access(1'b1, 4'h0, 32'h00001000, 32'h0, 1'b0);
        chk("oor_rd", data_rd, 32'd0);
        access(1'b0, 4'hF, 32'h00001000, 32'hCAFEF00D, 1'b0);
        access(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset mid-busy and on the edge that would enter RESP.
        abort_store(32'h20, 32'hA5A5A5A5, 1);
        access(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
        abort_store(32'h24, 32'h5A5A5A5A, LAT - 1);
        access(1'b1, 4'h0, 32'h24, 32'h0, 1'b0);

        // Load result persists through a later store.
        access(1'b0, 4'hF, 32'h10, 32'h12345678, 1'b0);
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        access(1'b0, 4'hF, 32'h30, 32'h87654321, 1'b0);
        @(negedge clk); #1;
        chk("rd_hold", data_rd, 32'h12345678);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h00001000;
            else a = {26'd0, 4'($urandom), 2'($urandom)};
            access(1'($urandom), 4'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); cs = 1'b1;
            end
        end
        @(negedge clk); cs = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
